// File: rtl/sweep_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sweep_pkg : shared state encoding and N range check for the
//             truth-table sweep controller.  Rev 1.0
// ------------------------------------------------------------------
package sweep_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  localparam int N_MIN = 1;
  localparam int N_MAX = 8;

  function automatic bit n_is_legal(input int n);
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mismatch_logger.sv
`default_nettype none
// ------------------------------------------------------------------
// mismatch_logger : counts output mismatches and latches the first
//                   failing vector of a sweep.  Rev 1.0
// ------------------------------------------------------------------
module mismatch_logger #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic         mismatch_i,
  input  logic [N-1:0] vec_i,
  output logic [N:0]   err_count_o,
  output logic         fail_seen_o,
  output logic [N-1:0] first_fail_o
);

  localparam logic [N:0] C_ONE = (N+1)'(1);

  logic [N:0]   err_count_q;
  logic         fail_seen_q;
  logic [N-1:0] first_fail_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      err_count_q  <= '0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= '0;
    end else if (en_i && mismatch_i) begin
      // N+1 bits hold 2^N, so the count can never overflow
      err_count_q <= err_count_q + C_ONE;
      if (!fail_seen_q) begin
        fail_seen_q  <= 1'b1;
        first_fail_q <= vec_i;
      end
    end
  end

  assign err_count_o  = err_count_q;
  assign fail_seen_o  = fail_seen_q;
  assign first_fail_o = first_fail_q;

endmodule
`default_nettype wire

// File: rtl/truth_table_sweep_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// truth_table_sweep_ctrl : sweeps all 2^N input vectors and compares
//                          two implementations of one function. Rev 1.0
// ------------------------------------------------------------------
module truth_table_sweep_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         pause_i,
  input  logic         s_a_i,
  input  logic         s_b_i,
  output logic [N-1:0] vec_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         pass_o,
  output logic [N:0]   err_count_o,
  output logic         fail_seen_o,
  output logic [N-1:0] first_fail_o
);

  import sweep_pkg::*;

  if (!n_is_legal(N)) begin : g_n_range_err
    $error("truth_table_sweep_ctrl: N must be in 1..8");
  end

  localparam logic [N-1:0] C_VEC_ONE = N'(1);

  state_e       state_q;
  logic [N-1:0] vec_q;
  logic [N-1:0] vec_d;
  logic         busy_q;
  logic         done_q;
  logic         w_take_start;
  logic         w_compare;

  assign w_take_start = start_i && (state_q != S_RUN);
  assign w_compare    = (state_q == S_RUN) && !pause_i;
  assign vec_d        = vec_q + C_VEC_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q <= S_RUN;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!pause_i) begin
            // the last vector holds so the status shows where the sweep ended
            if (&vec_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              vec_q <= vec_d;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          vec_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  mismatch_logger #(
    .N(N)
  ) u_logger (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (w_take_start),
    .en_i         (w_compare),
    .mismatch_i   (s_a_i ^ s_b_i),
    .vec_i        (vec_q),
    .err_count_o  (err_count_o),
    .fail_seen_o  (fail_seen_o),
    .first_fail_o (first_fail_o)
  );

  assign vec_o  = vec_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pass_o = done_q && (err_count_o == '0);

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweep_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_truth_table_sweep_ctrl : table-driven and randomized checks of
//                             the sweep controller at N=3 and N=4. Rev 1.0
// ------------------------------------------------------------------
module tb_truth_table_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause_i = 1'b0;
  logic start3 = 1'b0, start4 = 1'b0;

  logic       tt_a [256];
  logic       tt_b [256];

  logic [2:0] vec3, first3;
  logic [3:0] err3;
  logic       busy3, done3, pass3, seen3;
  logic [3:0] vec4, first4;
  logic [4:0] err4;
  logic       busy4, done4, pass4, seen4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  truth_table_sweep_ctrl #(.N(3)) u_dut3 (
    .clk(clk), .rst(rst), .start_i(start3), .pause_i(pause_i),
    .s_a_i(tt_a[vec3]), .s_b_i(tt_b[vec3]), .vec_o(vec3), .busy_o(busy3),
    .done_o(done3), .pass_o(pass3), .err_count_o(err3), .fail_seen_o(seen3),
    .first_fail_o(first3)
  );

  truth_table_sweep_ctrl #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .pause_i(pause_i),
    .s_a_i(tt_a[vec4]), .s_b_i(tt_b[vec4]), .vec_o(vec4), .busy_o(busy4),
    .done_o(done4), .pass_o(pass4), .err_count_o(err4), .fail_seen_o(seen4),
    .first_fail_o(first4)
  );

  typedef struct {
    int n;
    int mode;
    int pause_at;
    int pause_len;
    bit mid_start;
    bit start_paused;
    int exp_err;
    int exp_first;
    bit exp_pass;
    int exp_cycles;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_vec(int n);   return (n == 3) ? 32'(vec3)   : 32'(vec4);   endfunction
  function automatic logic [31:0] get_err(int n);   return (n == 3) ? 32'(err3)   : 32'(err4);   endfunction
  function automatic logic [31:0] get_first(int n); return (n == 3) ? 32'(first3) : 32'(first4); endfunction
  function automatic logic [31:0] get_busy(int n);  return (n == 3) ? 32'(busy3)  : 32'(busy4);  endfunction
  function automatic logic [31:0] get_done(int n);  return (n == 3) ? 32'(done3)  : 32'(done4);  endfunction
  function automatic logic [31:0] get_pass(int n);  return (n == 3) ? 32'(pass3)  : 32'(pass4);  endfunction
  function automatic logic [31:0] get_seen(int n);  return (n == 3) ? 32'(seen3)  : 32'(seen4);  endfunction

  task automatic drive_start(input int n, input logic v);
    if (n == 3) start3 = v; else start4 = v;
  endtask

  // Reference: mismatches among the first c vectors, and the lowest one.
  function automatic int errs_below(int c);
    int e = 0;
    for (int v = 0; v < c; v++) if (tt_a[v] != tt_b[v]) e++;
    return e;
  endfunction

  function automatic int first_below(int c);
    for (int v = 0; v < c; v++) if (tt_a[v] != tt_b[v]) return v;
    return 0;
  endfunction

  task automatic set_tables(input int mode);
    for (int v = 0; v < 256; v++) begin
      tt_a[v] = ~v[0];
      case (mode)
        1:       tt_b[v] = tt_a[v] ^ (v == 5);
        2:       tt_b[v] = ~tt_a[v];
        3: begin tt_a[v] = 1'($urandom); tt_b[v] = tt_a[v] ^ ($urandom_range(0, 3) == 0); end
        4:       tt_b[v] = tt_a[v] ^ (v == 2);
        default: tt_b[v] = tt_a[v];
      endcase
    end
  endtask

  task automatic sweep(input int n, input int pause_at, input int pause_len, input bit rand_pause,
                       input bit mid_start, input bit start_paused, output int cycles);
    int  last, n_cmp, plen, e;
    bit  p, exp_done;
    last = (1 << n) - 1;
    n_cmp = 0;
    plen = pause_len;
    cycles = 0;
    @(negedge clk);
    drive_start(n, 1'b1);
    pause_i = start_paused;
    @(negedge clk);
    drive_start(n, 1'b0);
    pause_i = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      e = errs_below(n_cmp);
      chk("run_vec", get_vec(n), (n_cmp < last) ? n_cmp : last);
      chk("run_busy", get_busy(n), 1);
      chk("run_pass", get_pass(n), 0);
      chk("run_err_count", get_err(n), e);
      chk("run_fail_seen", get_seen(n), (e != 0) ? 1 : 0);
      chk("run_first_fail", get_first(n), (e != 0) ? first_below(n_cmp) : 0);
      p = (pause_at == n_cmp && plen > 0) || (rand_pause && $urandom_range(0, 3) == 0);
      if (pause_at == n_cmp && plen > 0) plen--;
      pause_i = p;
      if (mid_start && k == 4) drive_start(n, 1'b1);
      @(negedge clk);
      pause_i = 1'b0;
      drive_start(n, 1'b0);
      if (!p) n_cmp++;
      exp_done = (n_cmp == last + 1);
      chk("run_done", get_done(n), exp_done ? 1 : 0);
      if (exp_done) begin
        cycles = k;
        break;
      end
    end
    if (cycles == 0) chk("sweep_timeout", 0, 1);
    chk("done_busy", get_busy(n), 0);
    chk("done_vec", get_vec(n), last);
    @(negedge clk);
    chk("hold_done", get_done(n), 1);
    chk("hold_vec", get_vec(n), last);
    chk("hold_err_count", get_err(n), errs_below(last + 1));
  endtask

  initial begin
    int cyc, n, e, k;

    tbl[0] = '{3, 0, -1, 0, 0, 0,  0, 0, 1,  8};
    tbl[1] = '{3, 1, -1, 0, 0, 0,  1, 5, 0,  8};
    tbl[2] = '{3, 0, -1, 0, 0, 0,  0, 0, 1,  8};
    tbl[3] = '{4, 2, -1, 0, 0, 0, 16, 0, 0, 16};
    tbl[4] = '{4, 0,  6, 3, 1, 0,  0, 0, 1, 19};
    tbl[5] = '{4, 0,  0, 1, 0, 1,  0, 0, 1, 17};

    set_tables(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_vec3", vec3, 0);
    chk("reset_busy3", busy3, 0);
    chk("reset_done3", done3, 0);
    chk("reset_pass3", pass3, 0);
    chk("reset_err4", err4, 0);
    chk("reset_seen4", seen4, 0);
    chk("reset_first4", first4, 0);

    for (int i = 0; i < 6; i++) begin
      set_tables(tbl[i].mode);
      sweep(tbl[i].n, tbl[i].pause_at, tbl[i].pause_len, 1'b0,
            tbl[i].mid_start, tbl[i].start_paused, cyc);
      chk($sformatf("row%0d_err_count", i), get_err(tbl[i].n), tbl[i].exp_err);
      chk($sformatf("row%0d_first_fail", i), get_first(tbl[i].n), tbl[i].exp_first);
      chk($sformatf("row%0d_fail_seen", i), get_seen(tbl[i].n), (tbl[i].exp_err != 0) ? 1 : 0);
      chk($sformatf("row%0d_pass", i), get_pass(tbl[i].n), tbl[i].exp_pass);
      chk($sformatf("row%0d_cycles", i), cyc, tbl[i].exp_cycles);
    end

    // Reset mid-sweep after one mismatch has been logged.
    set_tables(4);
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    k = 0;
    while (vec3 !== 3'd4 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_vec4", (k < 50) ? 1 : 0, 1);
    chk("pre_rst_err", err3, 1);
    chk("pre_rst_first", first3, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_vec", vec3, 0);
    chk("post_rst_busy", busy3, 0);
    chk("post_rst_done", done3, 0);
    chk("post_rst_pass", pass3, 0);
    chk("post_rst_err", err3, 0);
    chk("post_rst_seen", seen3, 0);
    chk("post_rst_first", first3, 0);
    @(negedge clk);
    chk("idle_after_rst_busy", busy3, 0);
    chk("idle_after_rst_vec", vec3, 0);
    set_tables(0);
    sweep(3, -1, 0, 1'b0, 1'b0, 1'b0, cyc);
    chk("fresh_pass", pass3, 1);
    chk("fresh_cycles", cyc, 8);

    for (int i = 0; i < 6; i++) begin
      n = ($urandom_range(0, 1) != 0) ? 4 : 3;
      set_tables(3);
      sweep(n, -1, 0, 1'b1, 1'b0, 1'b0, cyc);
      e = errs_below(1 << n);
      chk("rand_err_count", get_err(n), e);
      chk("rand_first_fail", get_first(n), (e != 0) ? first_below(1 << n) : 0);
      chk("rand_pass", get_pass(n), (e == 0) ? 1 : 0);
      chk("rand_min_cycles", (cyc >= (1 << n)) ? 1 : 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
